// File: rtl/pe_acc.sv
// pe_acc: two-stage registered adder tree over 32 signed lane products feeding a
// group accumulator whose result sits on a valid/ready port that stalls the whole pipe.
module pe_acc #(
    parameter int LANES = 32,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*32-1:0]     mult_result,
    input  logic                    mult_valid,
    output logic                    mult_ready,
    input  logic [7:0]              cfg_len,
    output logic signed [ACC_W-1:0] acc_result,
    output logic                    acc_valid,
    input  logic                    acc_ready,
    output logic                    busy
);
    localparam int GROUPS    = 4;
    localparam int GRP_LANES = LANES / GROUPS;
    localparam int PART_W    = 32 + $clog2(GRP_LANES);
    localparam int SUM_W     = PART_W + $clog2(GROUPS);

    function automatic logic signed [PART_W-1:0] sext_lane(input logic signed [31:0] v);
        return {{(PART_W-32){v[31]}}, v};
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_part(input logic signed [PART_W-1:0] v);
        return {{(SUM_W-PART_W){v[PART_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_sum(input logic signed [SUM_W-1:0] v);
        return {{(ACC_W-SUM_W){v[SUM_W-1]}}, v};
    endfunction

    // Two's complement add that silently wraps at ACC_W bits.
    function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [ACC_W-1:0] b);
        return a + b;
    endfunction

    logic                     adv;
    logic signed [PART_W-1:0] part_c [GROUPS];
    logic signed [PART_W-1:0] part_p0 [GROUPS];
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  sum_p1;
    logic                     vld_p0;
    logic                     vld_p1;
    logic [7:0]               cnt;
    logic [7:0]               len_q;
    logic signed [ACC_W-1:0]  acc;

    logic                     first;
    logic [7:0]               len_eff;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     step;
    logic                     last;
    logic                     last_fire;

    assign adv        = ~acc_valid | acc_ready;
    assign mult_ready = adv & ~rst;
    assign busy       = vld_p0 | vld_p1 | (cnt != 8'd0);

    // Stage p0: four partial sums of eight consecutive lanes each.
    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            part_c[g] = '0;
            for (int l = 0; l < GRP_LANES; l++) begin
                part_c[g] = part_c[g] + sext_lane(mult_result[(g*GRP_LANES+l)*32 +: 32]);
            end
        end
    end

    // Stage p1: reduce the partials to a single beat sum.
    always_comb begin
        sum_c = '0;
        for (int g = 0; g < GROUPS; g++) begin
            sum_c = sum_c + sext_part(part_p0[g]);
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            part_p0 <= part_c;
            sum_p1  <= sum_c;
        end
    end

    // Stage p2: group accumulation; cfg_len is captured only when a group opens.
    always_comb begin
        first     = (cnt == 8'd0);
        len_eff   = first ? ((cfg_len == 8'd0) ? 8'd1 : cfg_len) : len_q;
        addend    = sext_sum(sum_p1);
        acc_next  = first ? addend : wrap_add(acc, addend);
        step      = adv & vld_p1;
        last      = ({1'b0, cnt} + 9'd1) == {1'b0, len_eff};
        last_fire = step & last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            cnt        <= 8'd0;
            len_q      <= 8'd1;
            acc        <= '0;
            acc_result <= '0;
            acc_valid  <= 1'b0;
        end else begin
            if (adv) begin
                vld_p0 <= mult_valid;
                vld_p1 <= vld_p0;
            end
            if (step) begin
                acc <= acc_next;
                if (first) begin
                    len_q <= len_eff;
                end
                if (last) begin
                    cnt        <= 8'd0;
                    acc_result <= acc_next;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
            if (last_fire) begin
                acc_valid <= 1'b1;
            end else if (acc_ready) begin
                acc_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pe_acc.sv
// Self-checking bench for pe_acc: directed scenarios plus randomized streams,
// scored against a plain-arithmetic group-sum model.
module tb_pe_acc;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1023:0]      mult_result = '0;
    logic               mult_valid = 1'b0;
    logic               mult_ready;
    logic [7:0]         cfg_len = 8'd1;
    logic signed [47:0] acc_result;
    logic               acc_valid;
    logic               acc_ready = 1'b1;
    logic               busy;

    int errors = 0;
    int checks = 0;

    logic [1023:0] stim[$];
    logic [47:0]   got[$];
    int            sent = 0;
    int            accepted = 0;

    pe_acc #(.LANES(32), .ACC_W(48)) dut (
        .clk(clk), .rst(rst), .mult_result(mult_result), .mult_valid(mult_valid),
        .mult_ready(mult_ready), .cfg_len(cfg_len), .acc_result(acc_result),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && acc_valid && acc_ready) got.push_back(acc_result);
        if (mult_valid && mult_ready) accepted++;
    end

    function automatic logic [1023:0] fill(input logic [31:0] v);
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [1023:0] rand_beat();
        logic [1023:0] r;
        int mode;
        mode = $urandom_range(3);
        for (int k = 0; k < 32; k++) begin
            if (mode == 0) r[k*32 +: 32] = ($urandom_range(1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else           r[k*32 +: 32] = $urandom();
        end
        return r;
    endfunction

    // Reference: integer sum of all signed lanes of a beat.
    function automatic longint beat_sum(input logic [1023:0] d);
        longint s;
        s = 0;
        for (int k = 0; k < 32; k++) s += longint'($signed(d[k*32 +: 32]));
        return s;
    endfunction

    function automatic logic [47:0] group_sum(input int first_idx, input int len);
        longint s;
        s = 0;
        for (int k = first_idx; k < first_idx + len; k++) s += beat_sum(stim[k]);
        return s[47:0];
    endfunction

    // Send stim[sent..upto-1] with random valid/ready duty; wait for n_res results.
    task automatic run_stream(input int upto, input int vpct, input int rpct,
                              input int n_res, output int stalls);
        int cyc;
        cyc = 0;
        stalls = 0;
        while ((sent < upto || got.size() < n_res) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            acc_ready = ($urandom_range(99) < rpct);
            if (sent < upto && $urandom_range(99) < vpct) begin
                mult_valid  = 1'b1;
                mult_result = stim[sent];
            end else begin
                mult_valid = 1'b0;
            end
            #1;
            if (mult_valid && mult_ready) sent++;
            else if (mult_valid) stalls++;
        end
        @(negedge clk);
        mult_valid = 1'b0;
        acc_ready  = 1'b1;
        if (cyc >= 3000) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: sent=%0d results=%0d required sent=%0d results=%0d",
                     sent, got.size(), upto, n_res);
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        acc_ready  = 1'b1;
        mult_valid = 1'b0;
        @(negedge clk);
        while ((busy || acc_valid) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (busy !== 1'b0 || acc_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: busy=%b acc_valid=%b required 0 0", busy, acc_valid);
        end
    endtask

    task automatic new_run();
        stim.delete();
        got.delete();
        sent = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (acc_valid !== 1'b0 || acc_result !== 48'sd0 || busy !== 1'b0 || mult_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b result=%h busy=%b ready=%b required 0 0 0 0",
                     acc_valid, acc_result, busy, mult_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mult_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", mult_ready);
        end
    endtask

    task automatic test_single();
        logic [2:0] vld_seen;
        new_run();
        cfg_len   = 8'd1;
        acc_ready = 1'b1;
        @(negedge clk);
        mult_result = fill(32'd2);
        mult_valid  = 1'b1;
        @(negedge clk);
        mult_valid = 1'b0;
        vld_seen[0] = acc_valid;
        @(negedge clk);
        vld_seen[1] = acc_valid;
        @(negedge clk);
        vld_seen[2] = acc_valid;
        checks++;
        if (vld_seen !== 3'b100 || acc_result !== 48'sd64) begin
            errors++;
            $display("FAIL single_latency: valid history=%b result=%0d required 100 and 64",
                     vld_seen, acc_result);
        end
        @(negedge clk);
        checks++;
        if (acc_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: acc_valid=%b required 0", acc_valid);
        end
    endtask

    task automatic test_group4();
        logic [1023:0] d;
        int stalls;
        new_run();
        for (int k = 0; k < 32; k++) d[k*32 +: 32] = k;
        repeat (4) stim.push_back(d);
        cfg_len = 8'd4;
        run_stream(4, 100, 100, 1, stalls);
        drain();
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL group4_ready: stall cycles=%0d required 0", stalls);
        end
        checks++;
        if (got.size() !== 1 || got[0] !== 48'd1984) begin
            errors++;
            $display("FAIL group4_result: count=%0d first=%0d required 1 result of 1984",
                     got.size(), (got.size() > 0) ? got[0] : 48'd0);
        end
    endtask

    task automatic test_negative();
        int stalls;
        new_run();
        repeat (2) stim.push_back(fill(32'h8000_0000));
        cfg_len = 8'd2;
        run_stream(2, 100, 100, 1, stalls);
        drain();
        checks++;
        if (got.size() !== 1 || got[0] !== 48'hFFE0_0000_0000) begin
            errors++;
            $display("FAIL negative_sum: count=%0d first=%h required 1 result of ffe000000000",
                     got.size(), (got.size() > 0) ? got[0] : 48'd0);
        end
    endtask

    task automatic test_back_to_back();
        int acc0;
        new_run();
        cfg_len   = 8'd1;
        acc0      = accepted;
        for (int v = 1; v <= 3; v++) begin
            @(negedge clk);
            acc_ready   = 1'b0;
            mult_result = fill(v);
            mult_valid  = 1'b1;
        end
        @(negedge clk);
        mult_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (acc_valid !== 1'b1 || acc_result !== 48'sd32 || mult_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b result=%0d ready=%b required 1 32 0",
                         c, acc_valid, acc_result, mult_ready);
            end
            @(negedge clk);
        end
        drain();
        checks++;
        if (accepted - acc0 !== 3) begin
            errors++;
            $display("FAIL bp_accepted: got %0d beats required 3", accepted - acc0);
        end
        checks++;
        if (got.size() !== 3 || got[0] !== 48'd32 || got[1] !== 48'd64 || got[2] !== 48'd96) begin
            errors++;
            $display("FAIL bp_order: count=%0d required 3 results 32 64 96", got.size());
        end
    endtask

    task automatic test_len_cfg();
        int stalls;
        new_run();
        for (int b = 0; b < 2; b++) stim.push_back(rand_beat());
        cfg_len = 8'd0;
        run_stream(2, 100, 100, 2, stalls);
        drain();
        checks++;
        if (got.size() !== 2 || got[0] !== group_sum(0, 1) || got[1] !== group_sum(1, 1)) begin
            errors++;
            $display("FAIL len_zero: count=%0d required 2 single-beat results", got.size());
        end
        new_run();
        for (int b = 0; b < 5; b++) stim.push_back(rand_beat());
        cfg_len = 8'd3;
        run_stream(1, 100, 100, 0, stalls);
        repeat (4) @(negedge clk);
        cfg_len = 8'd2;
        run_stream(5, 100, 100, 2, stalls);
        drain();
        checks++;
        if (got.size() !== 2 || got[0] !== group_sum(0, 3) || got[1] !== group_sum(3, 2)) begin
            errors++;
            $display("FAIL len_change: count=%0d first=%h required 2 results %h %h",
                     got.size(), (got.size() > 0) ? got[0] : 48'd0, group_sum(0, 3), group_sum(3, 2));
        end
    endtask

    task automatic test_reset_mid();
        int stalls;
        new_run();
        stim.push_back(rand_beat());
        stim.push_back(rand_beat());
        cfg_len = 8'd4;
        run_stream(2, 100, 100, 0, stalls);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_group_busy: got %b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (acc_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b required 0 0", acc_valid, busy);
        end
        new_run();
        repeat (4) stim.push_back(fill(32'd1));
        run_stream(4, 100, 100, 1, stalls);
        drain();
        checks++;
        if (got.size() !== 1 || got[0] !== 48'd128) begin
            errors++;
            $display("FAIL fresh_group: count=%0d first=%0d required 1 result of 128",
                     got.size(), (got.size() > 0) ? got[0] : 48'd0);
        end
    endtask

    task automatic test_random();
        int len, eff, ngr, stalls;
        for (int r = 0; r < 5; r++) begin
            new_run();
            len = $urandom_range(5);
            eff = (len == 0) ? 1 : len;
            ngr = $urandom_range(2, 4);
            cfg_len = len[7:0];
            for (int b = 0; b < eff * ngr; b++) stim.push_back(rand_beat());
            run_stream(eff * ngr, 70, 60, ngr, stalls);
            drain();
            checks++;
            if (got.size() !== ngr) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d results required %0d", r, got.size(), ngr);
            end else begin
                for (int g = 0; g < ngr; g++) begin
                    checks++;
                    if (got[g] !== group_sum(g * eff, eff)) begin
                        errors++;
                        $display("FAIL rand%0d_group%0d: got %h required %h",
                                 r, g, got[g], group_sum(g * eff, eff));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_group4();
        test_negative();
        test_back_to_back();
        test_len_cfg();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
